audio_stream_ctrl: RTL and testbench

// - Audio playback stage fed by DATA_FSM: buffers unsigned 8-bit PCM bytes from the SPI/SD stream in a FIFO.
// - Pops one sample per audio_clk_en (8 kHz) and drives a 1-bit PWM output for the audio filter/amp on GPIO.
// - Raises need_data so the acquisition FSM can schedule audio reads between video bank fills.

---
 rtl/audio_pkg.sv | 8 +
 rtl/audio_fifo.sv | 64 ++++++
 rtl/audio_stream_ctrl.sv | 139 +++++++++++++
 tb/tb_audio_stream_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types and constants (PCM playback and the future I2S/codec path).
package audio_pkg;

   typedef enum logic [1:0] {AUD_IDLE, AUD_PREFILL, AUD_PLAY} aud_state_t;

   localparam logic [7:0] AUD_MIDSCALE = 8'h80;

endpackage

// File: rtl/audio_fifo.sv
// Single-clock sample FIFO with registered read data and push/pop/flush.
module audio_fifo #(
   parameter  int DEPTH  = 1024,
   parameter  int DATA_W = 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [AW:0]       level,
   output logic              full,
   output logic              empty,
   output logic              popped,
   output logic              dropped
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);

   // A pop frees a slot in the same cycle, so a write while full still lands.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign popped  = do_pop;
   assign dropped = push && !flush && full && !do_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Block-RAM style storage: no reset, read-old-data on address collision.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
      if (do_pop)  rd_data     <= mem[rd_ptr];
   end

endmodule

// File: rtl/audio_stream_ctrl.sv
// PCM playback stage: buffers stream bytes, pops one per audio strobe, drives 1-bit PWM.
module audio_stream_ctrl
   import audio_pkg::*;
#(
   parameter  int DEPTH       = 1024,
   parameter  int START_LEVEL = 512,
   parameter  int LOW_WM      = 256,
   parameter  int PWM_W       = 8,
   localparam int LW          = $clog2(DEPTH) + 1
) (
   input  logic             CLK_40,
   input  logic             reset,
   input  logic             audio_clk_en,
   input  logic             play_en,
   input  logic             flush,
   input  logic             write_audio,
   input  logic [PWM_W-1:0] audio_byte,
   output logic             need_data,
   output logic             fifo_full,
   output logic [LW-1:0]    fifo_level,
   output logic             overflow,
   output logic [7:0]       underrun_cnt,
   output logic [PWM_W-1:0] sample_out,
   output logic             pwm_out,
   output logic             playing
);

   localparam logic [LW-1:0]    START_LVL = LW'(START_LEVEL);
   localparam logic [LW-1:0]    LOW_LVL   = LW'(LOW_WM);
   localparam logic [PWM_W-1:0] MID       = PWM_W'(AUD_MIDSCALE);

   aud_state_t       state_q;
   aud_state_t       state_d;
   logic             underrun;
   logic             pop_req;
   logic             popped;
   logic             dropped;
   logic             empty;
   logic [PWM_W-1:0] rd_data_p1;
   logic             vld_p1;
   logic [PWM_W-1:0] sample_p2;
   logic [PWM_W-1:0] duty_q;
   logic [PWM_W-1:0] cnt_q;
   logic             pwm_q;
   logic             ovf_q;
   logic [7:0]       ucnt_q;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign pop_req = audio_clk_en && (state_q == AUD_PLAY);

   audio_fifo #(.DEPTH(DEPTH), .DATA_W(PWM_W)) u_fifo (
      .clk     (CLK_40),
      .rst     (reset),
      .push    (write_audio),
      .pop     (pop_req),
      .flush   (flush),
      .wr_data (audio_byte),
      .rd_data (rd_data_p1),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (empty),
      .popped  (popped),
      .dropped (dropped)
   );

   always_ff @(posedge CLK_40 or posedge reset) begin
      if (reset) state_q <= AUD_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      underrun = 1'b0;
      if (!play_en) begin
         state_d = AUD_IDLE;
      end else begin
         case (state_q)
            AUD_IDLE: state_d = AUD_PREFILL;
            // The flush empties the FIFO next cycle, so do not start playing on it.
            AUD_PREFILL: if (!flush && fifo_level >= START_LVL) state_d = AUD_PLAY;
            AUD_PLAY: begin
               if (flush) begin
                  state_d = AUD_PREFILL;
               end else if (audio_clk_en && empty) begin
                  state_d  = AUD_PREFILL;
                  underrun = 1'b1;
               end
            end
            default: state_d = AUD_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_40 or posedge reset) begin
      if (reset) begin
         ovf_q  <= 1'b0;
         ucnt_q <= '0;
      end else begin
         if (dropped)  ovf_q  <= 1'b1;
         if (underrun) ucnt_q <= sat_inc8(ucnt_q);
      end
   end

   // p1: RAM read data valid; p2: sample register (silence outside PLAY)
   always_ff @(posedge CLK_40 or posedge reset) begin
      if (reset) begin
         vld_p1    <= 1'b0;
         sample_p2 <= MID;
      end else begin
         vld_p1 <= popped;
         if (state_q != AUD_PLAY) sample_p2 <= MID;
         else if (vld_p1)         sample_p2 <= rd_data_p1;
      end
   end

   // Duty only reloads at the counter wrap, keeping each PWM period glitch-free.
   always_ff @(posedge CLK_40 or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         duty_q <= MID;
         pwm_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == '1) duty_q <= sample_p2;
         pwm_q <= (cnt_q < duty_q);
      end
   end

   assign need_data    = (fifo_level < LOW_LVL);
   assign overflow     = ovf_q;
   assign underrun_cnt = ucnt_q;
   assign sample_out   = sample_p2;
   assign pwm_out      = pwm_q;
   assign playing      = (state_q == AUD_PLAY);

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Scoreboard bench for audio_stream_ctrl, run with a reduced FIFO so saturation tests stay short.
module tb_audio_stream_ctrl;

   localparam int DEPTH = 64;
   localparam int START = 32;
   localparam int LOW   = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam logic [7:0] MID = 8'h80;

   logic          CLK_40 = 1'b0;
   logic          reset = 1'b1;
   logic          audio_clk_en = 1'b0;
   logic          play_en = 1'b0;
   logic          flush = 1'b0;
   logic          write_audio = 1'b0;
   logic [7:0]    audio_byte = 8'h00;
   logic          need_data;
   logic          fifo_full;
   logic [LW-1:0] fifo_level;
   logic          overflow;
   logic [7:0]    underrun_cnt;
   logic [7:0]    sample_out;
   logic          pwm_out;
   logic          playing;

   always #5 CLK_40 = ~CLK_40;

   audio_stream_ctrl #(.DEPTH(DEPTH), .START_LEVEL(START), .LOW_WM(LOW), .PWM_W(8)) dut (
      .CLK_40       (CLK_40),
      .reset        (reset),
      .audio_clk_en (audio_clk_en),
      .play_en      (play_en),
      .flush        (flush),
      .write_audio  (write_audio),
      .audio_byte   (audio_byte),
      .need_data    (need_data),
      .fifo_full    (fifo_full),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .underrun_cnt (underrun_cnt),
      .sample_out   (sample_out),
      .pwm_out      (pwm_out),
      .playing      (playing)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: state as a name, FIFO as a byte queue, pops scheduled by due cycle.
   localparam int M_IDLE = 0, M_PREFILL = 1, M_PLAY = 2;
   typedef struct { int due; logic [7:0] val; } pend_t;
   typedef struct {
      int level; bit need; bit full; bit ovf; int ucnt; logic [7:0] sample; bit pwm; bit playing;
   } exp_t;

   int         m_st;
   logic [7:0] m_q[$];
   pend_t      m_pend[$];
   bit         m_ovf;
   int         m_ucnt;
   logic [7:0] m_sample;
   logic [7:0] m_duty;
   bit         m_pwm;
   int         m_t;
   exp_t       exp_q[$];
   exp_t       mon_e;

   function automatic exp_t snap();
      exp_t r;
      r.level   = m_q.size();
      r.need    = (m_q.size() < LOW);
      r.full    = (m_q.size() == DEPTH);
      r.ovf     = m_ovf;
      r.ucnt    = m_ucnt;
      r.sample  = m_sample;
      r.pwm     = m_pwm;
      r.playing = (m_st == M_PLAY);
      return r;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_q.delete(); m_pend.delete(); m_ovf = 0; m_ucnt = 0;
      m_sample = MID; m_duty = MID; m_pwm = 0; m_t = 0;
      exp_q.delete();
      exp_q.push_back(snap());
   endtask

   task automatic model_step();
      int lvl;
      bit pop;
      pend_t p;
      lvl = m_q.size();
      pop = audio_clk_en && (m_st == M_PLAY) && (lvl > 0) && !flush;
      m_pwm = ((m_t % 256) < m_duty);
      if ((m_t % 256) == 255) m_duty = m_sample;
      while (m_pend.size() > 0 && m_pend[0].due <= m_t + 1) begin
         p = m_pend.pop_front();
         if (m_st == M_PLAY && p.due == m_t + 1) m_sample = p.val;
      end
      if (m_st != M_PLAY) m_sample = MID;
      if (flush) begin
         m_q.delete();
      end else begin
         if (pop) m_pend.push_back('{m_t + 2, m_q.pop_front()});
         if (write_audio) begin
            if (m_q.size() < DEPTH) m_q.push_back(audio_byte);
            else m_ovf = 1;
         end
      end
      if (!play_en) m_st = M_IDLE;
      else if (m_st == M_IDLE) m_st = M_PREFILL;
      else if (m_st == M_PREFILL) begin
         if (!flush && lvl >= START) m_st = M_PLAY;
      end else begin
         if (flush) m_st = M_PREFILL;
         else if (audio_clk_en && lvl == 0) begin
            m_st = M_PREFILL;
            if (m_ucnt < 255) m_ucnt++;
         end
      end
      m_t++;
      exp_q.push_back(snap());
   endtask

   always @(posedge CLK_40 or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
   end

   always @(negedge CLK_40) begin
      if (!reset && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("fifo_level",   32'(fifo_level),   32'(mon_e.level));
         check("need_data",    32'(need_data),    32'(mon_e.need));
         check("fifo_full",    32'(fifo_full),    32'(mon_e.full));
         check("overflow",     32'(overflow),     32'(mon_e.ovf));
         check("underrun_cnt", 32'(underrun_cnt), 32'(mon_e.ucnt));
         check("sample_out",   32'(sample_out),   32'(mon_e.sample));
         check("pwm_out",      32'(pwm_out),      32'(mon_e.pwm));
         check("playing",      32'(playing),      32'(mon_e.playing));
      end
   end

   task automatic cyc(input bit en, input bit pe, input bit fl, input bit wr, input logic [7:0] b);
      audio_clk_en = en; play_en = pe; flush = fl; write_audio = wr; audio_byte = b;
      @(posedge CLK_40);
      #1;
   endtask

   task automatic idle(input bit pe, input int n);
      for (int i = 0; i < n; i++) cyc(0, pe, 0, 0, 8'h00);
   endtask

   task automatic drain_to_underrun(output bit ok);
      ok = 0;
      for (int i = 0; i < 4 * DEPTH; i++) begin
         cyc(1, 1, 0, 0, 8'h00);
         cyc(0, 1, 0, 0, 8'h00);
         if (!playing) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic pwm_window(input logic [7:0] val, output int highs);
      cyc(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, val);
      idle(1, 3);
      cyc(1, 1, 0, 0, 8'h00);
      idle(1, 300);
      highs = 0;
      for (int i = 0; i < 512; i++) begin
         cyc(0, 1, 0, 0, 8'h00);
         if (pwm_out) highs++;
      end
   endtask

   logic [7:0] b0;
   int         lvl_keep;
   int         highs;
   bit         ok;
   int         wthr;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge CLK_40);
      #1 reset = 1'b0;
      check("reset_level", 32'(fifo_level), 0);
      check("reset_sample", 32'(sample_out), 32'(MID));

      // Prefill: START-1 bytes keep silence, the next one starts playback
      cyc(0, 1, 0, 0, 8'h00);
      b0 = 8'($urandom);
      cyc(0, 1, 0, 1, b0);
      for (int i = 1; i < START - 1; i++) cyc(0, 1, 0, 1, 8'($urandom));
      idle(1, 2);
      check("prefill_not_playing", 32'(playing), 0);
      check("prefill_sample", 32'(sample_out), 32'(MID));
      cyc(0, 1, 0, 1, 8'($urandom));
      cyc(0, 1, 0, 0, 8'h00);
      check("prefill_to_play", 32'(playing), 1);
      cyc(1, 1, 0, 0, 8'h00);
      cyc(0, 1, 0, 0, 8'h00);
      check("first_sample", 32'(sample_out), 32'(b0));

      // Underrun after START+1 strobes with no refill
      for (int i = 0; i < START; i++) begin
         cyc(1, 1, 0, 0, 8'h00);
         idle(1, 2);
      end
      check("underrun_state", 32'(playing), 0);
      check("underrun_cnt1", 32'(underrun_cnt), 1);
      check("underrun_sample", 32'(sample_out), 32'(MID));

      // flush with a simultaneous write
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 8'($urandom));
      cyc(0, 1, 1, 1, 8'h5A);
      check("flush_level", 32'(fifo_level), 0);
      check("flush_no_ovf", 32'(overflow), 0);

      // Random traffic, alternating fast and slow writers
      for (int s = 0; s < 6; s++) begin
         wthr = (s % 2 == 0) ? 4 : 1;
         for (int i = 0; i < 500; i++)
            cyc(($urandom % 4) == 0, ($urandom % 300) != 0, ($urandom % 250) == 0,
                ($urandom % 8) < wthr, 8'($urandom));
      end

      // Full FIFO: drop, then write+pop while full
      cyc(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 8'($urandom));
      check("full_flag", 32'(fifo_full), 1);
      cyc(0, 0, 0, 1, 8'hEE);
      check("full_drop_level", 32'(fifo_level), DEPTH);
      check("full_overflow", 32'(overflow), 1);
      idle(1, 3);
      check("full_playing", 32'(playing), 1);
      cyc(1, 1, 0, 1, 8'hA5);
      check("full_wr_pop_level", 32'(fifo_level), DEPTH);

      // Drop play_en mid-play
      idle(1, 2);
      lvl_keep = int'(fifo_level);
      cyc(0, 0, 0, 0, 8'h00);
      check("drop_play_idle", 32'(playing), 0);
      check("drop_play_level", 32'(fifo_level), 32'(lvl_keep));

      // PWM duty
      pwm_window(8'h40, highs);
      check("pwm_duty_40", 32'(highs), 128);
      pwm_window(8'h00, highs);
      check("pwm_duty_00", 32'(highs), 0);

      // Underrun counter saturation
      for (int k = 0; k < 300; k++) begin
         drain_to_underrun(ok);
         if (!ok) begin
            check("underrun_timeout", 0, 1);
            break;
         end
         for (int i = 0; i < START; i++) cyc(0, 1, 0, 1, 8'($urandom));
         idle(1, 1);
      end
      drain_to_underrun(ok);
      check("underrun_sat", 32'(underrun_cnt), 255);

      // Asynchronous reset mid-play
      for (int i = 0; i < 44; i++) cyc(0, 1, 0, 1, 8'($urandom));
      idle(1, 2);
      check("pre_reset_level", 32'(fifo_level), 44);
      check("pre_reset_playing", 32'(playing), 1);
      @(posedge CLK_40);
      #3 reset = 1'b1;
      #1;
      check("arst_level", 32'(fifo_level), 0);
      check("arst_need", 32'(need_data), 1);
      check("arst_full", 32'(fifo_full), 0);
      check("arst_ovf", 32'(overflow), 0);
      check("arst_ucnt", 32'(underrun_cnt), 0);
      check("arst_sample", 32'(sample_out), 32'(MID));
      check("arst_pwm", 32'(pwm_out), 0);
      check("arst_playing", 32'(playing), 0);
      @(posedge CLK_40);
      @(posedge CLK_40);
      #1 reset = 1'b0;
      for (int i = 0; i < 300; i++)
         cyc(($urandom % 3) == 0, 1, 0, ($urandom % 2) == 0, 8'($urandom));
      idle(1, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
